// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port RAM between the instruction
// fetch port (read-only) and the data port (read/write). One transaction at a
// time, round-robin on contention, and the RAM's one-cycle read latency is
// absorbed by a dedicated READ state.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    // RAM side
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // status
    output logic              busy,
    output logic              last_grant
);

    typedef enum logic [1:0] {IDLE, ACCESS, READ} state_t;

    state_t              r_state;
    logic                r_port;        // 0 = fetch, 1 = data
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_we;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_if_ack;
    logic                r_d_ack;
    logic                r_busy;
    logic                r_last_grant;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    logic                w_gnt_d;
    logic                w_gnt_if;
    logic                w_rd_done;

    // Data wins when fetch is idle or when fetch was served last.
    assign w_gnt_d  = d_req & (~if_req | ~r_last_grant);
    assign w_gnt_if = if_req & ~w_gnt_d;

    // Read completion cycle; a reset cycle never completes anything.
    assign w_rd_done = (r_state == READ) & rst_n;

    // Strobes are masked by reset so a reset cycle never writes or acks.
    assign mem_we     = r_mem_we & rst_n;
    assign if_ack     = r_if_ack & rst_n;
    assign d_ack      = r_d_ack & rst_n;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign busy       = r_busy;
    assign last_grant = r_last_grant;

    // Read data bypasses straight from the RAM in the ack cycle, otherwise
    // the capture register holds the last completed read of that port.
    assign if_rdata = (w_rd_done && !r_port) ? mem_rdata : r_if_rdata;
    assign d_rdata  = (w_rd_done &&  r_port) ? mem_rdata : r_d_rdata;

    // Arbitration FSM; RAM controls, acks and busy are registered with the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_port       <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_if_ack     <= 1'b0;
            r_d_ack      <= 1'b0;
            r_busy       <= 1'b0;
            r_last_grant <= 1'b1;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_if || w_gnt_d) begin
                        r_state      <= ACCESS;
                        r_port       <= w_gnt_d;
                        r_last_grant <= w_gnt_d;
                        r_mem_addr   <= w_gnt_d ? d_addr : if_addr;
                        r_mem_wdata  <= w_gnt_d ? d_wdata : '0;
                        r_mem_we     <= w_gnt_d & d_we;
                        // A write completes in the ACCESS cycle itself.
                        r_d_ack      <= w_gnt_d & d_we;
                        r_if_ack     <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (r_mem_we) begin
                        r_state     <= IDLE;
                        r_mem_addr  <= '0;
                        r_mem_we    <= 1'b0;
                        r_mem_wdata <= '0;
                        r_d_ack     <= 1'b0;
                        r_busy      <= 1'b0;
                    end else begin
                        // Keep the address up while the RAM returns data.
                        r_state     <= READ;
                        r_mem_wdata <= '0;
                        r_if_ack    <= ~r_port;
                        r_d_ack     <= r_port;
                    end
                end
                READ: begin
                    if (r_port) r_d_rdata  <= mem_rdata;
                    else        r_if_rdata <= mem_rdata;
                    r_state    <= IDLE;
                    r_mem_addr <= '0;
                    r_if_ack   <= 1'b0;
                    r_d_ack    <= 1'b0;
                    r_busy     <= 1'b0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_mem_addr <= '0;
                    r_mem_we   <= 1'b0;
                    r_if_ack   <= 1'b0;
                    r_d_ack    <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: hand sequences for reset/latency/contention corners,
// a vector table of single transactions, and a randomized run checked against
// a transaction-level model (RAM image + grant order + latency arithmetic).
module tb_mem_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;
    logic          last_grant;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM with one-cycle read latency.
    logic [DW-1:0] ram [256] = '{8'h05: 16'h1234, default: 16'h0000};
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Transaction-level model state.
    logic [DW-1:0] mram [256];
    logic          m_last;
    logic [DW-1:0] m_if_rd, m_d_rd;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rd;
    } vec_t;
    vec_t vecs [8];

    // One isolated transaction from IDLE; checks latency, strobes and holds.
    task automatic do_txn(input string nm, input vec_t v);
        logic [DW-1:0] d_before, if_before;
        int lat;
        bit got;
        d_before = d_rdata; if_before = if_rdata;
        @(negedge clk);
        if (v.port) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        lat = 0; got = 0;
        while (!got && lat < 8) begin
            bit ack_now;
            @(negedge clk); lat++;
            ack_now = v.port ? d_ack : if_ack;
            chk({nm, " mem_we"}, mem_we, v.we && ack_now);
            chk({nm, " other ack"}, v.port ? if_ack : d_ack, 0);
            if (ack_now) begin
                got = 1;
                chk({nm, " mem_addr"}, mem_addr, v.addr);
                if (v.we) chk({nm, " mem_wdata"}, mem_wdata, v.wdata);
                else      chk({nm, " rdata"}, v.port ? d_rdata : if_rdata, v.exp_rd);
                if_req = 1'b0; d_req = 1'b0;
            end
        end
        chk({nm, " latency"}, lat, v.we ? 1 : 2);
        @(negedge clk);
        chk({nm, " busy after"}, busy, 0);
        chk({nm, " last_grant"}, last_grant, v.port);
        if (v.we) chk({nm, " d_rdata kept"}, d_rdata, d_before);
        else      chk({nm, " rdata held"}, v.port ? d_rdata : if_rdata, v.exp_rd);
        chk({nm, " other rdata kept"}, v.port ? if_rdata : d_rdata, v.port ? if_before : d_before);
        if (v.we) mram[v.addr] = v.wdata;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mram[i] = '0;
        mram[8'h05] = 16'h1234;

        vecs[0] = '{1'b1, 1'b1, 8'h10, 16'hBEEF, 16'h0000};
        vecs[1] = '{1'b1, 1'b0, 8'h10, 16'h0000, 16'hBEEF};
        vecs[2] = '{1'b0, 1'b0, 8'h10, 16'h0000, 16'hBEEF};
        vecs[3] = '{1'b1, 1'b1, 8'hFF, 16'hA5C3, 16'h0000};
        vecs[4] = '{1'b0, 1'b0, 8'hFF, 16'h0000, 16'hA5C3};
        vecs[5] = '{1'b1, 1'b1, 8'h00, 16'h7FFF, 16'h0000};
        vecs[6] = '{1'b1, 1'b0, 8'h00, 16'h0000, 16'h7FFF};
        vecs[7] = '{1'b1, 1'b0, 8'h05, 16'h0000, 16'h1234};

        // Reset state, then a single fetch read of 0x05.
        do_reset();
        chk("rst busy", busy, 0);
        chk("rst last_grant", last_grant, 1);
        chk("rst if_rdata", if_rdata, 0);
        chk("rst d_rdata", d_rdata, 0);
        chk("rst acks", {if_ack, d_ack}, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst mem_addr", mem_addr, 0);
        if_req = 1'b1; if_addr = 8'h05;
        @(negedge clk);
        chk("fetch c1 mem_addr", mem_addr, 8'h05);
        chk("fetch c1 if_ack", if_ack, 0);
        chk("fetch c1 busy", busy, 1);
        @(negedge clk);
        chk("fetch c2 mem_addr", mem_addr, 8'h05);
        chk("fetch c2 if_ack", if_ack, 1);
        chk("fetch c2 if_rdata", if_rdata, 16'h1234);
        if_req = 1'b0;
        @(negedge clk);
        chk("fetch c3 if_ack", if_ack, 0);
        chk("fetch c3 if_rdata", if_rdata, 16'h1234);
        chk("fetch c3 last_grant", last_grant, 0);
        chk("fetch c3 busy", busy, 0);

        // Vector table of isolated transactions.
        foreach (vecs[i]) do_txn($sformatf("vec%0d", i), vecs[i]);

        // Contention: both reads held from reset; grants alternate fetch/data.
        do_reset();
        if_req = 1'b1; if_addr = 8'h05;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk($sformatf("cont c%0d if_ack", c), if_ack, (c == 2 || c == 8));
            chk($sformatf("cont c%0d d_ack", c), d_ack, (c == 5 || c == 11));
            if (if_ack) chk($sformatf("cont c%0d if_rdata", c), if_rdata, 16'h1234);
            if (d_ack)  chk($sformatf("cont c%0d d_rdata", c), d_rdata, 16'hBEEF);
        end
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);

        // Data request arriving during a fetch's ACCESS cycle waits its turn.
        begin
            int if_c, d_c;
            if_c = 0; d_c = 0;
            @(negedge clk);
            if_req = 1'b1; if_addr = 8'h05;
            @(negedge clk);
            chk("busy-req access busy", busy, 1);
            d_req = 1'b1; d_we = 1'b0; d_addr = 8'hFF;
            for (int c = 2; c <= 9; c++) begin
                @(negedge clk);
                if (if_ack) begin if_c = c; if_req = 1'b0; end
                if (d_ack) begin
                    d_c = c; d_req = 1'b0;
                    chk("busy-req d_rdata", d_rdata, 16'hA5C3);
                end
            end
            chk("busy-req if_ack cycle", if_c, 2);
            chk("busy-req d_ack cycle", d_c, 5);
        end

        // Reset during the ACCESS cycle of a write.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 16'h5555;
        @(negedge clk);
        chk("rst-wr access busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst-wr mem_we", mem_we, 0);
        chk("rst-wr d_ack", d_ack, 0);
        @(negedge clk);
        d_req = 1'b0; rst_n = 1'b1;
        chk("rst-wr busy", busy, 0);
        chk("rst-wr d_ack after", d_ack, 0);
        @(negedge clk);
        chk("rst-wr ram", ram[8'h20], 16'h0000);

        // Reset during READ: no ack, capture registers cleared.
        do_txn("pre fetch", '{1'b0, 1'b0, 8'h05, 16'h0, 16'h1234});
        do_txn("pre data", '{1'b1, 1'b0, 8'h10, 16'h0, 16'hBEEF});
        @(negedge clk);
        if_req = 1'b1; if_addr = 8'h10;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0; if_req = 1'b0;
        #1;
        chk("rst-rd if_ack", if_ack, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst-rd if_rdata", if_rdata, 0);
        chk("rst-rd d_rdata", d_rdata, 0);
        chk("rst-rd busy", busy, 0);

        // Randomized pairs of requests against the transaction-level model.
        m_last = 1'b1; m_if_rd = '0; m_d_rd = '0;
        for (int it = 0; it < 60; it++) begin
            bit fi, di, dwe, first, gotf, gotd;
            logic [AW-1:0] fa, da;
            logic [DW-1:0] dwd, exp_f, exp_d;
            int lat_f, lat_d, cyc_f, cyc_d;
            fi = 1'($urandom_range(0, 1)); di = 1'($urandom_range(0, 1));
            if (!fi && !di) di = 1'b1;
            fa = 8'($urandom_range(0, 15)); da = 8'($urandom_range(0, 15));
            dwe = 1'($urandom_range(0, 1)); dwd = 16'($urandom);
            lat_f = 2; lat_d = dwe ? 1 : 2;
            first = (fi && di) ? ~m_last : di;
            if (first) begin
                cyc_d = lat_d; cyc_f = fi ? lat_d + 1 + lat_f : 0;
            end else begin
                cyc_f = lat_f; cyc_d = di ? lat_f + 1 + lat_d : 0;
            end
            exp_f = '0; exp_d = '0;
            // Apply the served transactions to the model in grant order.
            for (int k = 0; k < 2; k++) begin
                bit p;
                p = (k == 0) ? first : ~first;
                if (p && di) begin
                    if (dwe) mram[da] = dwd;
                    else begin exp_d = mram[da]; m_d_rd = exp_d; end
                    m_last = 1'b1;
                end else if (!p && fi) begin
                    exp_f = mram[fa]; m_if_rd = exp_f;
                    m_last = 1'b0;
                end
            end
            @(negedge clk);
            if_req = fi; if_addr = fa;
            d_req = di; d_we = dwe; d_addr = da; d_wdata = dwd;
            gotf = !fi; gotd = !di;
            for (int c = 1; c <= 12 && !(gotf && gotd); c++) begin
                @(negedge clk);
                chk("rnd dual ack", if_ack & d_ack, 0);
                if (if_ack) begin
                    chk($sformatf("rnd%0d if cycle", it), c, cyc_f);
                    chk($sformatf("rnd%0d if_rdata", it), if_rdata, exp_f);
                    if_req = 1'b0; gotf = 1'b1;
                end
                if (d_ack) begin
                    chk($sformatf("rnd%0d d cycle", it), c, cyc_d);
                    if (!dwe) chk($sformatf("rnd%0d d_rdata", it), d_rdata, exp_d);
                    d_req = 1'b0; gotd = 1'b1;
                end
            end
            chk($sformatf("rnd%0d completed", it), {gotf, gotd}, 2'b11);
            if_req = 1'b0; d_req = 1'b0;
            @(negedge clk);
            chk($sformatf("rnd%0d last_grant", it), last_grant, m_last);
            chk($sformatf("rnd%0d if_rdata hold", it), if_rdata, m_if_rd);
            chk($sformatf("rnd%0d d_rdata hold", it), d_rdata, m_d_rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port synchronous RAM between the instruction-fetch requester (read-only) and the data requester (LDR/STR, read or write). It sits between the CPU sequencer and the RAM. It serialises accesses with a req/ack handshake and round-robin priority, and absorbs the RAM's one-cycle read latency. Consumers of this block treat `ack` as the only completion indication.

## Interface
Parameters:
- ADDR_W, 8, RAM address width
- DATA_W, 16, RAM data width

Ports:
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  reset, synchronous, active-low
- if_req  in  1  fetch read request; level, held until if_ack
- if_addr  in  ADDR_W  fetch address; stable while if_req high
- if_ack  out  1  fetch completion pulse, 1 cycle
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request; level, held until d_ack
- d_we  in  1  1 = write, 0 = read; stable while d_req high
- d_addr  in  ADDR_W  data address; stable while d_req high
- d_wdata  in  DATA_W  write data; stable while d_req high
- d_ack  out  1  data completion pulse, 1 cycle
- d_rdata  out  DATA_W  data read data
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data; valid the cycle after the address is presented
- busy  out  1  high whenever state is not IDLE
- last_grant  out  1  0 = fetch, 1 = data; port granted most recently

## Operation
- The FSM has three states: IDLE, ACCESS and READ.
- **IDLE:** the block samples requests.
  - Neither request is high: the FSM stays in IDLE.
  - Exactly one request is high: that port is granted.
  - Both requests are high: the port that is not last_grant is granted.
  - On grant, at the posedge: latch the port id, address, we (0 for fetch) and wdata; update last_grant; go to ACCESS.
- **ACCESS:** mem_addr = latched addr and mem_wdata = latched wdata.
  - Write: mem_we=1 and the granted ack=1. Next state is IDLE.
  - Read: mem_we=0. Next state is READ.
- **READ:** mem_addr is held at the latched addr.
  - The granted ack=1.
  - The granted rdata output equals mem_rdata combinationally in this cycle.
  - The posedge captures mem_rdata into that port's rdata register. Next state is IDLE.
- **rdata outputs:** outside its own READ-ack cycle, each rdata output shows its capture register. The value holds until that port's next read completes. A write never changes d_rdata.
- **IDLE outputs:** mem_addr=0, mem_we=0, mem_wdata=0, both acks 0.
- **Request release:** a requester drops req, or changes to a new request, in the cycle after its ack. If req is still high in the following IDLE cycle, it is treated as a new request.
- **Requests while busy:** requests arriving while busy are ignored until IDLE. Only one transaction is in flight at a time.
- **Round-robin:** with both ports requesting continuously, grants alternate strictly: fetch, data, fetch, and so on.

## Timing
- **Reset values:** state=IDLE, last_grant=1 (so fetch wins the first contested grant), if_rdata=0, d_rdata=0, acks 0, mem_we=0, busy=0.
- **Reset gating:** mem_we and both acks are ANDed with rst_n. A cycle with rst_n=0 therefore never writes RAM or acknowledges, even in ACCESS or READ.
- **Reset mid-transaction:** the transaction is abandoned with no ack and no rdata update. The requester must re-request.
- **Latency, request high in IDLE cycle T:**
  - Write: ack in T+1; next grant sampled in T+2.
  - Read: ack with data in T+2; next grant sampled in T+3.
- **Throughput:** 1 write per 2 cycles, 1 read per 3 cycles.
- **Contention:** a losing port waits at most one transaction (2 or 3 cycles) before it is granted.
- **Address wrap:** addresses are used unmodified; there is no wrap logic.

## Test plan
- **Reset, then single fetch:** reset, preload RAM[0x05]=0x1234, if_req=1 with if_addr=0x05 in cycle 0 -> mem_addr=0x05 in cycles 1–2; if_ack=1 with if_rdata=0x1234 in cycle 2 only; last_grant=0; if_rdata holds 0x1234 afterwards.
- **Data write then read:** d_we=1, d_addr=0x10, d_wdata=0xBEEF -> mem_we=1 in cycle 1 only, d_ack in cycle 1; d_rdata unchanged. Then a d_we=0 read of 0x10 -> d_ack with d_rdata=0xBEEF 2 cycles after sampling.
- **Contention:** both requests high from reset, both as reads, each re-requesting immediately after its ack -> grant order fetch, data, fetch, data; acks in cycles 2, 5, 8, 11; never both acks in the same cycle.
- **Request during busy:** d_req raised in the ACCESS cycle of a fetch read -> d_req is not granted until the IDLE cycle after if_ack, so d_ack follows 2 or 3 cycles later.
- **Reset mid-write:** rst_n=0 during the ACCESS cycle of a write to 0x20 (RAM[0x20]=0x0000) -> mem_we=0, no d_ack, RAM[0x20] stays 0x0000, state=IDLE and busy=0 next cycle.
- **Reset mid-read:** rst_n=0 during READ -> no ack; both rdata outputs are 0 next cycle.
